// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling asynchronous serial receiver.
// Recovers start / data / optional parity / stop frames from rxd, samples
// each bit at its midpoint, and hands every byte to the sink as a one-clock
// strobe with framing and parity status.

`timescale 1ns/1ps

module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_bps16,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [3:0] MID_START = 4'd7;
   localparam logic [3:0] MID_BIT = 4'd15;

   // Synchroniser and edge-detect flops
   logic rxd_meta;
   logic rxd_s;
   logic bps_meta;
   logic bps_sync;
   logic bps_prev;
   logic tick;

   // FSM and datapath state
   state_t                 state_q;
   state_t                 state_nx;
   logic [3:0]             tick_cnt_q;
   logic [3:0]             tick_cnt_nx;
   logic [2:0]             bit_cnt_q;
   logic [2:0]             bit_cnt_nx;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   shift_nx;
   logic                   par_q;
   logic                   par_nx;
   logic                   done;
   logic [7:0]             data_ext;
   logic                   parity_bad;

   // Bring the asynchronous serial line into the clk domain; the idle level
   // of the line is high, so the flops come out of reset high to avoid a
   // phantom start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

   // Synchronise the oversample clock and turn each of its rising edges into
   // a single-cycle tick, three clocks after the input edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bps_meta <= 1'b0;
         bps_sync <= 1'b0;
         bps_prev <= 1'b0;
         tick     <= 1'b0;
      end else begin
         bps_meta <= clk_bps16;
         bps_sync <= bps_meta;
         bps_prev <= bps_sync;
         tick     <= bps_sync & ~bps_prev;
      end
   end

   // FSM state, oversample counter, bit counter and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
      end else begin
         state_q    <= state_nx;
         tick_cnt_q <= tick_cnt_nx;
         bit_cnt_q  <= bit_cnt_nx;
         shift_q    <= shift_nx;
         par_q      <= par_nx;
      end
   end

   // Next-state logic. Nothing moves except in tick cycles, so a stalled
   // oversample clock simply freezes the receiver where it is. Data bits
   // are sampled on the sixteenth tick after the previous sample point,
   // which lands in the middle of each bit because the start bit was
   // qualified at its own midpoint.
   always_comb begin
      state_nx    = state_q;
      tick_cnt_nx = tick_cnt_q;
      bit_cnt_nx  = bit_cnt_q;
      shift_nx    = shift_q;
      par_nx      = par_q;
      done        = 1'b0;

      if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_nx    = START;
                  tick_cnt_nx = '0;
               end
            end

            START: begin
               if (tick_cnt_q == MID_START) begin
                  tick_cnt_nx = '0;
                  bit_cnt_nx  = '0;
                  state_nx    = rxd_s ? IDLE : DATA;
               end else begin
                  tick_cnt_nx = tick_cnt_q + 4'd1;
               end
            end

            DATA: begin
               tick_cnt_nx = tick_cnt_q + 4'd1;
               if (tick_cnt_q == MID_BIT) begin
                  shift_nx = {rxd_s, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_nx = '0;
                     state_nx   = PARITY_EN ? PARITY : STOP;
                  end else begin
                     bit_cnt_nx = bit_cnt_q + 3'd1;
                  end
               end
            end

            PARITY: begin
               tick_cnt_nx = tick_cnt_q + 4'd1;
               if (tick_cnt_q == MID_BIT) begin
                  par_nx   = rxd_s;
                  state_nx = STOP;
               end
            end

            STOP: begin
               tick_cnt_nx = tick_cnt_q + 4'd1;
               if (tick_cnt_q == MID_BIT) begin
                  done     = 1'b1;
                  state_nx = rxd_s ? IDLE : BREAK;
               end
            end

            BREAK: begin
               if (rxd_s) begin
                  state_nx = IDLE;
               end
            end

            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   // Zero-extend the received word and work out the parity verdict for the
   // frame that is about to be reported.
   always_comb begin
      data_ext                = '0;
      data_ext[DATA_BITS-1:0] = shift_q;
      parity_bad              = PARITY_EN && ((^shift_q) ^ par_q ^ PARITY_ODD);
   end

   // Output register: one-clock strobe with the frame result. rx_data keeps
   // the last byte between frames while the error flags drop with the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else if (done) begin
         rx_data       <= data_ext;
         rx_valid      <= 1'b1;
         rx_frame_err  <= ~rxd_s;
         rx_parity_err <= parity_bad;
      end else begin
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end
   end

   assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives two receivers (8N1 and 8E1) with directed and random
// frames and compares every strobe against a frame-level model queue.

`timescale 1ns/1ps

module tb_uart_rx;

   typedef struct packed {
      logic [7:0] data;
      logic       frame_err;
      logic       parity_err;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_bps16 = 1'b0;
   logic       rxd_a = 1'b1;
   logic       rxd_b = 1'b1;

   logic [7:0] rx_data_a;
   logic       rx_valid_a;
   logic       rx_frame_err_a;
   logic       rx_parity_err_a;
   logic       rx_busy_a;
   logic [7:0] rx_data_b;
   logic       rx_valid_b;
   logic       rx_frame_err_b;
   logic       rx_parity_err_b;
   logic       rx_busy_b;

   frame_t     exp_a[$];
   frame_t     exp_b[$];
   frame_t     got_a;
   frame_t     got_b;
   int         vector_count = 0;
   int         miscompare_count = 0;
   int         valid_count_a = 0;
   int         valid_count_b = 0;
   logic       prev_valid_a = 1'b0;
   logic       prev_valid_b = 1'b0;
   int         div_cnt = 0;
   int         base;

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_bps16     (clk_bps16),
      .rxd           (rxd_a),
      .rx_data       (rx_data_a),
      .rx_valid      (rx_valid_a),
      .rx_frame_err  (rx_frame_err_a),
      .rx_parity_err (rx_parity_err_a),
      .rx_busy       (rx_busy_a)
   );

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_bps16     (clk_bps16),
      .rxd           (rxd_b),
      .rx_data       (rx_data_b),
      .rx_valid      (rx_valid_b),
      .rx_frame_err  (rx_frame_err_b),
      .rx_parity_err (rx_parity_err_b),
      .rx_busy       (rx_busy_b)
   );

   // 50 MHz system clock
   always #10 clk = ~clk;

   // Oversample clock: one period every 8 system clocks
   always @(posedge clk) begin
      div_cnt   <= (div_cnt == 7) ? 0 : div_cnt + 1;
      clk_bps16 <= (div_cnt < 4);
   end

   // Safety net so the run always ends
   initial begin
      repeat (95000) @(posedge clk);
      $display("[TB] FAIL watchdog: run exceeded 95000 cycles, expected completion earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miscompare_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Frame-level model: data as sent, frame error when the stop bit is 0,
   // parity error when the count of ones over data+parity is odd (even mode)
   function automatic frame_t modelFrame(input int lane, input logic [7:0] data,
                                         input logic par, input logic stop);
      frame_t f;
      f.data       = data;
      f.frame_err  = ~stop;
      f.parity_err = (lane == 1) ? ((($countones(data) + int'(par)) % 2) != 0) : 1'b0;
      return f;
   endfunction

   task automatic driveBit(input int lane, input logic b, input int ticks);
      if (lane == 0) rxd_a = b;
      else           rxd_b = b;
      repeat (ticks) @(posedge clk_bps16);
   endtask

   // Send one frame; lane 1 carries a parity bit. The line is left at the
   // stop-bit level so callers can extend a break.
   task automatic applyStimulus(input int lane, input logic [7:0] data, input logic par,
                                input logic stop, input bit expect_it);
      if (expect_it) begin
         if (lane == 0) exp_a.push_back(modelFrame(lane, data, par, stop));
         else           exp_b.push_back(modelFrame(lane, data, par, stop));
      end
      driveBit(lane, 1'b0, 16);
      for (int i = 0; i < 8; i++) driveBit(lane, data[i], 16);
      if (lane == 1) driveBit(lane, par, 16);
      driveBit(lane, stop, 16);
   endtask

   // Scoreboard for the 8N1 receiver
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid_a = 1'b0;
      end else begin
         if (rx_valid_a) begin
            valid_count_a++;
            checkOutput("a_pulse_width", 32'(prev_valid_a), 32'd0);
            if (exp_a.size() == 0) begin
               checkOutput("a_unexpected_valid", 32'(rx_valid_a), 32'd0);
            end else begin
               got_a = exp_a.pop_front();
               checkOutput("a_data", 32'(rx_data_a), 32'(got_a.data));
               checkOutput("a_frame_err", 32'(rx_frame_err_a), 32'(got_a.frame_err));
               checkOutput("a_parity_err", 32'(rx_parity_err_a), 32'(got_a.parity_err));
            end
         end else begin
            checkOutput("a_ferr_idle", 32'(rx_frame_err_a), 32'd0);
            checkOutput("a_perr_idle", 32'(rx_parity_err_a), 32'd0);
         end
         prev_valid_a = rx_valid_a;
      end
   end

   // Scoreboard for the 8E1 receiver
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid_b = 1'b0;
      end else begin
         if (rx_valid_b) begin
            valid_count_b++;
            checkOutput("b_pulse_width", 32'(prev_valid_b), 32'd0);
            if (exp_b.size() == 0) begin
               checkOutput("b_unexpected_valid", 32'(rx_valid_b), 32'd0);
            end else begin
               got_b = exp_b.pop_front();
               checkOutput("b_data", 32'(rx_data_b), 32'(got_b.data));
               checkOutput("b_frame_err", 32'(rx_frame_err_b), 32'(got_b.frame_err));
               checkOutput("b_parity_err", 32'(rx_parity_err_b), 32'(got_b.parity_err));
            end
         end else begin
            checkOutput("b_ferr_idle", 32'(rx_frame_err_b), 32'd0);
            checkOutput("b_perr_idle", 32'(rx_parity_err_b), 32'd0);
         end
         prev_valid_b = rx_valid_b;
      end
   end

   initial begin
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         gap;

      // Reset state
      repeat (4) @(negedge clk);
      checkOutput("reset_data", 32'(rx_data_a), 32'd0);
      checkOutput("reset_valid", 32'(rx_valid_a), 32'd0);
      checkOutput("reset_busy", 32'(rx_busy_a), 32'd0);
      checkOutput("reset_ferr", 32'(rx_frame_err_a), 32'd0);
      checkOutput("reset_perr", 32'(rx_parity_err_b), 32'd0);
      rst_n = 1'b1;
      driveBit(0, 1'b1, 32);

      // Plain 8N1 frame
      base = valid_count_a;
      applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      checkOutput("t1_pulses", 32'(valid_count_a - base), 32'd1);
      checkOutput("t1_busy_after", 32'(rx_busy_a), 32'd0);
      driveBit(0, 1'b1, 16);

      // Short low glitch is rejected, next frame still lands
      base = valid_count_a;
      driveBit(0, 1'b0, 4);
      driveBit(0, 1'b1, 32);
      checkOutput("t2_glitch_pulses", 32'(valid_count_a - base), 32'd0);
      checkOutput("t2_glitch_busy", 32'(rx_busy_a), 32'd0);
      applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      driveBit(0, 1'b1, 16);

      // Bad stop bit then held-low line: one errored strobe, then silence
      base = valid_count_a;
      applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
      driveBit(0, 1'b0, 48);
      checkOutput("t3_break_pulses", 32'(valid_count_a - base), 32'd1);
      checkOutput("t3_break_busy", 32'(rx_busy_a), 32'd1);
      driveBit(0, 1'b1, 16);
      checkOutput("t3_release_busy", 32'(rx_busy_a), 32'd0);
      applyStimulus(0, 8'h81, 1'b0, 1'b1, 1'b1);
      driveBit(0, 1'b1, 16);

      // Even parity: correct and wrong parity bit
      base = valid_count_b;
      applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1);
      driveBit(1, 1'b1, 16);
      applyStimulus(1, 8'h07, 1'b0, 1'b1, 1'b1);
      driveBit(1, 1'b1, 16);
      checkOutput("t4_pulses", 32'(valid_count_b - base), 32'd2);

      // Back-to-back frames with no idle gap
      base = valid_count_a;
      applyStimulus(0, 8'h00, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 8'hFF, 1'b0, 1'b1, 1'b1);
      driveBit(0, 1'b1, 16);
      checkOutput("t5_pulses", 32'(valid_count_a - base), 32'd2);

      // Reset during data bit 3 of 0xC3
      base = valid_count_a;
      driveBit(0, 1'b0, 16);
      driveBit(0, 1'b1, 16);
      driveBit(0, 1'b1, 16);
      driveBit(0, 1'b0, 16);
      driveBit(0, 1'b0, 8);
      checkOutput("t6_busy_mid", 32'(rx_busy_a), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      rxd_a = 1'b1;
      @(negedge clk);
      checkOutput("t6_reset_data", 32'(rx_data_a), 32'd0);
      checkOutput("t6_reset_valid", 32'(rx_valid_a), 32'd0);
      checkOutput("t6_reset_busy", 32'(rx_busy_a), 32'd0);
      checkOutput("t6_reset_ferr", 32'(rx_frame_err_a), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      driveBit(0, 1'b1, 32);
      checkOutput("t6_no_pulse", 32'(valid_count_a - base), 32'd0);
      applyStimulus(0, 8'h5A, 1'b0, 1'b1, 1'b1);
      driveBit(0, 1'b1, 16);

      // Random frames on both receivers
      for (int n = 0; n < 24; n++) begin
         data = 8'($urandom);
         par  = 1'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         applyStimulus(n % 2, data, par, stop, 1'b1);
         driveBit(n % 2, 1'b1, 16 * gap);
      end

      driveBit(0, 1'b1, 32);
      checkOutput("a_frames_pending", 32'(exp_a.size()), 32'd0);
      checkOutput("b_frames_pending", 32'(exp_b.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
      $finish;
   end

endmodule
